// File: rtl/tpu_gemm_pkg.sv
// Shared constants, derivation helpers and writer FSM encoding for the
// GEMM/convolution data path (data mover and result writer).
package tpu_gemm_pkg;

    localparam int MEM_DEPTH_DEF      = 896;
    localparam int MEM_ADDR_WIDTH_DEF = 10;
    localparam int MEM_DATA_WIDTH_DEF = 128;
    localparam int PE_SIZE_DEF        = 16;
    localparam int ACC_WIDTH_DEF      = 32;
    localparam int ROW_CNT_WIDTH_DEF  = 10;

    function automatic int calc_lanes_per_word(input int mem_data_width, input int acc_width);
        return mem_data_width / acc_width;
    endfunction

    function automatic int calc_words_per_row(input int pe_size, input int acc_width,
                                              input int mem_data_width);
        return (pe_size * acc_width) / mem_data_width;
    endfunction

    // A single-word row still needs a one-bit beat counter to keep the ports legal.
    function automatic int calc_beat_width(input int words_per_row);
        return (words_per_row > 1) ? $clog2(words_per_row) : 1;
    endfunction

    localparam int LANES_PER_WORD = calc_lanes_per_word(MEM_DATA_WIDTH_DEF, ACC_WIDTH_DEF);
    localparam int WORDS_PER_ROW  = calc_words_per_row(PE_SIZE_DEF, ACC_WIDTH_DEF,
                                                       MEM_DATA_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } writer_state_t;

endpackage

// File: rtl/conv_result_writer_unpacker.sv
// Row buffer and beat multiplexer for the result writer.
// Optional: define CONV_RESULT_WRITER_RELU_EN to clamp negative lanes to zero at capture.
import tpu_gemm_pkg::*;

module conv_row_unpacker #(
    parameter int PE_SIZE        = PE_SIZE_DEF,
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF,
    parameter int BEAT_WIDTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]  row_data,
    input  logic [BEAT_WIDTH-1:0]         beat_sel,
    output logic [MEM_DATA_WIDTH-1:0]     word
);

    localparam int ROW_WIDTH   = PE_SIZE * ACC_WIDTH;
    localparam int WORDS       = calc_words_per_row(PE_SIZE, ACC_WIDTH, MEM_DATA_WIDTH);

    logic [ROW_WIDTH-1:0]      row_buf;
    logic [ROW_WIDTH-1:0]      capture_data;
    logic [MEM_DATA_WIDTH-1:0] words [WORDS];

`ifdef CONV_RESULT_WRITER_RELU_EN
    // Clamping before the register keeps ReLU off the write-beat timing path.
    always_comb begin
        capture_data = row_data;
        for (int i = 0; i < PE_SIZE; i++) begin
            if (row_data[i*ACC_WIDTH + ACC_WIDTH - 1]) begin
                capture_data[i*ACC_WIDTH +: ACC_WIDTH] = '0;
            end
        end
    end
`else
    assign capture_data = row_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf <= '0;
        end else if (load) begin
            row_buf <= capture_data;
        end
    end

    for (genvar k = 0; k < WORDS; k++) begin : g_words
        assign words[k] = row_buf[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end

    assign word = words[beat_sel];

endmodule

// File: rtl/conv_result_writer.sv
// Drains PE result rows into the output BRAM as sequential word writes.
// Optional: define CONV_RESULT_WRITER_RELU_EN to clamp negative lanes to zero at capture.
import tpu_gemm_pkg::*;

module conv_result_writer #(
    parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
    parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
    parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF,
    parameter int PE_SIZE        = PE_SIZE_DEF,
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int ROW_CNT_WIDTH  = ROW_CNT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [ROW_CNT_WIDTH-1:0]      num_rows_i,
    input  logic [MEM_ADDR_WIDTH-1:0]     base_addr_i,
    input  logic                          row_valid_i,
    output logic                          row_ready_o,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]  row_data_i,
    output logic [MEM_ADDR_WIDTH-1:0]     mem2_addr0,
    output logic                          mem2_ce0,
    output logic                          mem2_we0,
    output logic [MEM_DATA_WIDTH-1:0]     mem2_d0,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int WORDS_PER_ROW_P = calc_words_per_row(PE_SIZE, ACC_WIDTH, MEM_DATA_WIDTH);
    localparam int BEAT_WIDTH      = calc_beat_width(WORDS_PER_ROW_P);

    localparam logic [BEAT_WIDTH-1:0]     LAST_BEAT = BEAT_WIDTH'(WORDS_PER_ROW_P - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

    writer_state_t state, next_state;

    logic [ROW_CNT_WIDTH-1:0]  num_rows;
    logic [ROW_CNT_WIDTH-1:0]  rows_accepted;
    logic [MEM_ADDR_WIDTH-1:0] addr_cnt;
    logic [BEAT_WIDTH-1:0]     beat_cnt;
    logic                      buf_full;
    logic                      last_beat;
    logic                      accept;

    assign last_beat = buf_full && (beat_cnt == LAST_BEAT);
    assign accept    = row_valid_i && row_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The buffer may be refilled on its last beat so a row every
    // WORDS_PER_ROW cycles streams without a bubble.
    always_comb begin
        next_state  = state;
        row_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = (num_rows_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o      = 1'b1;
                row_ready_o = (rows_accepted < num_rows) &&
                              (!buf_full || (beat_cnt == LAST_BEAT));
                if (last_beat && (rows_accepted == num_rows)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_rows      <= '0;
            rows_accepted <= '0;
            addr_cnt      <= '0;
            beat_cnt      <= '0;
            buf_full      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        num_rows      <= num_rows_i;
                        addr_cnt      <= base_addr_i;
                        rows_accepted <= '0;
                        beat_cnt      <= '0;
                        buf_full      <= 1'b0;
                    end
                end
                RUN: begin
                    if (buf_full) begin
                        addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
                        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
                    end
                    if (accept) begin
                        buf_full      <= 1'b1;
                        rows_accepted <= rows_accepted + 1'b1;
                    end else if (last_beat) begin
                        buf_full <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    conv_row_unpacker #(
        .PE_SIZE        (PE_SIZE),
        .ACC_WIDTH      (ACC_WIDTH),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
        .BEAT_WIDTH     (BEAT_WIDTH)
    ) u_unpacker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .row_data (row_data_i),
        .beat_sel (beat_cnt),
        .word     (mem2_d0)
    );

    assign mem2_addr0 = addr_cnt;
    assign mem2_ce0   = buf_full;
    assign mem2_we0   = buf_full;

endmodule

// File: tb/tb_conv_result_writer.sv
// Testbench for conv_result_writer.
import tpu_gemm_pkg::*;

module tb_conv_result_writer;

    localparam int DEPTH = 896;
    localparam int AW    = 10;
    localparam int DW    = 128;
    localparam int PE    = 16;
    localparam int ACC   = 32;
    localparam int RW    = 10;
    localparam int W     = 4;
    localparam int LPW   = DW / ACC;

`ifdef CONV_RESULT_WRITER_RELU_EN
    localparam logic [ACC-1:0] RELU_EXP = 32'h0000_0000;
`else
    localparam logic [ACC-1:0] RELU_EXP = 32'hFFFF_FFF0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [RW-1:0]  num_rows_i;
    logic [AW-1:0]  base_addr_i;
    logic           row_valid_i;
    logic           row_ready_o;
    logic [PE*ACC-1:0] row_data_i;
    logic [AW-1:0]  mem2_addr0;
    logic           mem2_ce0;
    logic           mem2_we0;
    logic [DW-1:0]  mem2_d0;
    logic           busy_o;
    logic           done_o;

    conv_result_writer #(
        .MEM_DEPTH      (DEPTH),
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .PE_SIZE        (PE),
        .ACC_WIDTH      (ACC),
        .ROW_CNT_WIDTH  (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .num_rows_i  (num_rows_i),
        .base_addr_i (base_addr_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .row_data_i  (row_data_i),
        .mem2_addr0  (mem2_addr0),
        .mem2_ce0    (mem2_ce0),
        .mem2_we0    (mem2_we0),
        .mem2_d0     (mem2_d0),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Port-0 write log of the BRAM, sampled mid-cycle.
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    int            done_q    [$];
    int            ready_cnt = 0;

    always @(negedge clk) begin
        if (mem2_ce0 && mem2_we0) begin
            wr_addr_q.push_back(mem2_addr0);
            wr_data_q.push_back(mem2_d0);
            wr_cyc_q.push_back(cyc);
        end
        if (done_o) done_q.push_back(cyc);
        if (row_ready_o) ready_cnt = ready_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    int job_wr_start;
    int job_done_start;
    int job_ready_start;
    int job_en_cyc;
    logic [PE*ACC-1:0] rows_q [$];

    typedef struct {
        int base;
        int rows;
        int stall;
        int pattern;
        bit glitch;
        int exp_writes;
        int exp_first;
        int exp_last;
        int exp_span;
    } vec_t;

    task automatic check_output(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ACC-1:0] ref_lane(input logic [ACC-1:0] v);
`ifdef CONV_RESULT_WRITER_RELU_EN
        return v[ACC-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic apply_stimulus(input int base, input int rows, input int stall,
                                  input int pattern, input bit glitch);
        logic [PE*ACC-1:0] d;
        logic [ACC-1:0]    lane;
        int                wait_cnt;
        rows_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int i = 0; i < PE; i++) begin
                case (pattern)
                    0:       lane = ACC'(r * PE + i);
                    2:       lane = (i == 0) ? 32'hFFFF_FFF0 : $urandom;
                    default: lane = $urandom;
                endcase
                d[i*ACC +: ACC] = lane;
            end
            rows_q.push_back(d);
        end
        @(negedge clk);
        job_wr_start    = wr_addr_q.size();
        job_done_start  = done_q.size();
        job_ready_start = ready_cnt;
        job_en_cyc      = cyc;
        en          = 1'b1;
        base_addr_i = AW'(base);
        num_rows_i  = RW'(rows);
        @(negedge clk);
        en          = 1'b0;
        base_addr_i = AW'($urandom);
        num_rows_i  = RW'($urandom);
        check_output("busy_after_en", DW'(busy_o), DW'(1'b1));
        for (int r = 0; r < rows; r++) begin
            row_data_i  = rows_q[r];
            row_valid_i = (r == 0) || (stall == 0);
            wait_cnt = 0;
            while (!row_ready_o && wait_cnt < 100) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!row_ready_o) begin
                check_output("ready_timeout", DW'(row_ready_o), DW'(1'b1));
                break;
            end
            if (r > 0 && stall > 0) begin
                row_valid_i = 1'b0;
                repeat (stall) @(negedge clk);
                row_valid_i = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (glitch && r == 0) begin
                en          = 1'b1;
                num_rows_i  = RW'(5);
                base_addr_i = AW'(10'h3F0);
                @(negedge clk);
                en = 1'b0;
            end
        end
        row_valid_i = 1'b0;
        wait_cnt = 0;
        while (!done_o && wait_cnt < 300) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_output("done_seen", DW'(done_o), DW'(1'b1));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_job(input int writes, input int first, input int last,
                             input int span, input int rows, input int stall, input int base);
        logic [DW-1:0]     img [DEPTH];
        logic [DW-1:0]     ew;
        logic [PE*ACC-1:0] rd;
        logic [ACC-1:0]    lane;
        int n;
        int li;
        int addr;
        n  = wr_addr_q.size() - job_wr_start;
        li = wr_addr_q.size() - 1;
        check_output("write_count", DW'(n), DW'(writes));
        check_output("done_count", DW'(done_q.size() - job_done_start), DW'(1));
        if (writes > 0 && n > 0) begin
            check_output("first_addr", DW'(wr_addr_q[job_wr_start]), DW'(first));
            check_output("last_addr", DW'(wr_addr_q[li]), DW'(last));
            check_output("write_span", DW'(wr_cyc_q[li] - wr_cyc_q[job_wr_start] + 1), DW'(span));
            if (done_q.size() > job_done_start)
                check_output("done_latency", DW'(done_q[job_done_start] - wr_cyc_q[li]), DW'(1));
        end else if (writes == 0 && done_q.size() > job_done_start) begin
            check_output("done_latency_empty", DW'(done_q[job_done_start] - job_en_cyc), DW'(1));
        end
        if (stall == 0)
            check_output("ready_cycles", DW'(ready_cnt - job_ready_start), DW'(rows));
        for (int a = 0; a < DEPTH; a++) img[a] = 'x;
        for (int i = job_wr_start; i < wr_addr_q.size(); i++) img[wr_addr_q[i]] = wr_data_q[i];
        for (int r = 0; r < rows_q.size(); r++) begin
            rd = rows_q[r];
            for (int k = 0; k < W; k++) begin
                for (int j = 0; j < LPW; j++) begin
                    lane = rd[(k*LPW + j)*ACC +: ACC];
                    ew[j*ACC +: ACC] = ref_lane(lane);
                end
                addr = (base + r*W + k) % DEPTH;
                check_output($sformatf("word@%0d", addr), img[addr], ew);
            end
        end
    endtask

    vec_t vecs [7];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0]  w0;
        logic [ACC-1:0] l0;
        int b;
        int nr;
        int st;

        vecs[0] = '{10'h010, 1, 0, 0, 1'b0,  4, 10'h010, 10'h013,  4};
        vecs[1] = '{10'h100, 8, 0, 1, 1'b0, 32, 10'h100, 10'h11F, 32};
        vecs[2] = '{894,     1, 0, 1, 1'b0,  4, 894,     1,        4};
        vecs[3] = '{10'h200, 3, 5, 1, 1'b0, 12, 10'h200, 10'h20B, 22};
        vecs[4] = '{10'h050, 0, 0, 1, 1'b0,  0, 0,       0,        0};
        vecs[5] = '{880,     6, 2, 1, 1'b0, 24, 880,     7,       34};
        vecs[6] = '{10'h300, 2, 0, 2, 1'b1,  8, 10'h300, 10'h307,  8};

        rst_n       = 1'b0;
        en          = 1'b0;
        num_rows_i  = '0;
        base_addr_i = '0;
        row_valid_i = 1'b0;
        row_data_i  = '0;
        #12;
        check_output("rst_ready", DW'(row_ready_o), '0);
        check_output("rst_ce",    DW'(mem2_ce0), '0);
        check_output("rst_we",    DW'(mem2_we0), '0);
        check_output("rst_addr",  DW'(mem2_addr0), '0);
        check_output("rst_data",  mem2_d0, '0);
        check_output("rst_busy",  DW'(busy_o), '0);
        check_output("rst_done",  DW'(done_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d base=%0d rows=%0d stall=%0d", i, vecs[i].base,
                     vecs[i].rows, vecs[i].stall);
            apply_stimulus(vecs[i].base, vecs[i].rows, vecs[i].stall, vecs[i].pattern,
                           vecs[i].glitch);
            check_job(vecs[i].exp_writes, vecs[i].exp_first, vecs[i].exp_last, vecs[i].exp_span,
                      vecs[i].rows, vecs[i].stall, vecs[i].base);
            if (vecs[i].pattern == 0 && wr_data_q.size() > job_wr_start) begin
                w0 = wr_data_q[job_wr_start];
                check_output("word0_lane_idx", w0,
                             128'h00000003_00000002_00000001_00000000);
            end
            if (vecs[i].pattern == 2 && wr_data_q.size() > job_wr_start) begin
                w0 = wr_data_q[job_wr_start];
                l0 = w0[ACC-1:0];
                check_output("relu_lane0", DW'(l0), DW'(RELU_EXP));
            end
            if (i == 0) check_output("idle_busy", DW'(busy_o), '0);
        end

        for (int t = 0; t < 4; t++) begin
            b  = $urandom_range(0, DEPTH - 1);
            nr = $urandom_range(1, 4);
            st = $urandom_range(0, 3);
            $display("[TB] random job base=%0d rows=%0d stall=%0d", b, nr, st);
            apply_stimulus(b, nr, st, 1, 1'b0);
            check_job(nr*W, b, (b + nr*W - 1) % DEPTH, nr*W + (nr - 1)*st, nr, st, b);
        end

        // Reset in the middle of a row, then restart from a new base.
        @(negedge clk);
        en          = 1'b1;
        base_addr_i = AW'(10'h040);
        num_rows_i  = RW'(2);
        @(negedge clk);
        en          = 1'b0;
        row_valid_i = 1'b1;
        row_data_i  = {16{$urandom}};
        @(posedge clk);
        @(negedge clk);
        row_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("ce_before_rst", DW'(mem2_ce0), DW'(1'b1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("ce_async_drop", DW'(mem2_ce0), '0);
        check_output("we_async_drop", DW'(mem2_we0), '0);
        check_output("busy_async_drop", DW'(busy_o), '0);
        check_output("addr_async_clr", DW'(mem2_addr0), '0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(10'h060, 1, 0, 1, 1'b0);
        check_job(4, 10'h060, 10'h063, 4, 1, 0, 10'h060);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
Drain-side counterpart of the convolution data mover: accepts completed result rows from the PE array and writes them into the output BRAM (mem2, true_dpbram port 0).
Each row is PE_SIZE signed accumulators, unpacked into MEM_DATA_WIDTH-bit words and written at sequential addresses from a programmable base.
Completion is signalled by a one-cycle done pulse so the top-level controller can start the next tile.

Parameters:
MEM_DEPTH, 896, output BRAM depth in words
MEM_ADDR_WIDTH, 10, BRAM address width
MEM_DATA_WIDTH, 128, BRAM word width
PE_SIZE, 16, accumulators per result row
ACC_WIDTH, 32, bits per accumulator (signed)
ROW_CNT_WIDTH, 10, width of row-count input
Derived constants:
- LANES_PER_WORD = MEM_DATA_WIDTH/ACC_WIDTH (4).
- WORDS_PER_ROW = PE_SIZE*ACC_WIDTH/MEM_DATA_WIDTH (4); must be an integer ≥1.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  start pulse, sampled only in IDLE
num_rows_i  in  ROW_CNT_WIDTH  rows to write this run, sampled with en
base_addr_i  in  MEM_ADDR_WIDTH  first write address, sampled with en
row_valid_i  in  1  result row present
row_ready_o  out  1  writer can take a row
row_data_i  in  PE_SIZE*ACC_WIDTH  row; lane 0 at bits [ACC_WIDTH-1:0]
mem2_addr0  out  MEM_ADDR_WIDTH  BRAM address
mem2_ce0  out  1  BRAM chip enable
mem2_we0  out  1  BRAM write enable
mem2_d0  out  MEM_DATA_WIDTH  BRAM write data
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle pulse after the last word is written

Behaviour:
- Reset: state=IDLE; buffer empty; all counters 0. row_ready_o=0, mem2_ce0=0, mem2_we0=0, mem2_addr0=0, mem2_d0=0, busy_o=0, done_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - en=1 latches num_rows_i and base_addr_i.
  - num_rows_i≠0 → RUN.
  - num_rows_i=0 → DONE; done pulses the next cycle and no write occurs.
- RUN:
  - row_ready_o = !buf_full || (beat_cnt==WORDS_PER_ROW-1), gated by rows_accepted<num_rows.
  - Handshake fires on the rising edge with row_valid_i && row_ready_o. That edge latches row_data_i into the row buffer, sets buf_full, and increments rows_accepted.
- Write beats:
  - mem2_* outputs are driven only from registered state; there is no combinational path from any input.
  - mem2_ce0 = mem2_we0 = buf_full.
  - mem2_addr0 = addr_cnt.
  - mem2_d0 = buffer word beat_cnt, where word k = lanes [k*LANES_PER_WORD +: LANES_PER_WORD].
- Latency:
  - Row accepted at edge N → write strobes asserted in cycles N+1..N+WORDS_PER_ROW.
  - A row on every 4th cycle streams with no gaps (100% write duty).
- Per beat:
  - addr_cnt increments by 1.
  - At MEM_DEPTH-1 it wraps to 0.
  - beat_cnt wraps at WORDS_PER_ROW-1. On that beat, buf_full clears unless a new row is accepted on the same edge (simultaneous drain and fill keeps it full).
- RUN→DONE on the edge where the last beat of row num_rows is written.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE. busy_o is low in IDLE.
  - en in RUN/DONE is ignored.
- row_valid_i with row_ready_o=0: row is held by the upstream source; nothing is lost or duplicated.
- Asynchronous reset mid-run: strobes drop immediately, and the partial row is discarded.

Optional Feature:
CONV_RESULT_WRITER_RELU_EN
- Defined: each lane is passed through ReLU (a negative value, i.e. MSB=1, is replaced by 0) at buffer capture, so it adds no extra latency.
- Undefined: lanes are written bit-exact.

Decomposition:
- Shared package (tpu_gemm_pkg) holds:
  - the WORDS_PER_ROW and LANES_PER_WORD derivation;
  - an FSM state typedef (IDLE/RUN/DONE, 2 bits);
  - default MEM/PE constants shared with the data mover.
- One sub-module, conv_row_unpacker: the row buffer plus beat mux and optional ReLU. The FSM, counters and handshake stay in the top module.

Test Plan:
- Single row: base=0x010, num_rows=1, lane i=i.
  - 4 writes at 0x010–0x013.
  - Word 0 = {32'd3,32'd2,32'd1,32'd0}.
  - done pulses 1 cycle after the 0x013 write.
- Back-to-back: num_rows=8, row_valid held high.
  - 32 consecutive write cycles with no gap; addresses base..base+31.
  - row_ready_o is high on every 4th cycle only.
- Wrap: base=894, num_rows=1.
  - Addresses 894, 895, 0, 1.
- Backpressure/stall: row_valid dropped for 5 cycles between rows, then reasserted.
  - The ce/we gap equals the stall length; no duplicate or missing words (checked against a true_dpbram model).
- Edge cases:
  - num_rows=0 → no ce0, done after 1 cycle.
  - en asserted during RUN → ignored.
  - rst_n low mid-row → ce0/we0 drop asynchronously; restart writes from the new base.
- RELU_EN:
  - Lane value 32'hFFFF_FFF0 is written as 0 when the macro is defined, and unchanged when it is not.
